// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen
// Transmit side of an OV7670 DVP pixel port. Walks the frame with VGA-style
// vertical/horizontal timing, fetches one RGB565 pixel per two pclk cycles
// during active lines and sends it as two bytes, high byte first.
//
// Ports:
//   pclk        pixel clock, all logic on its rising edge
//   rst         synchronous reset, active-high
//   en          frame enable, looked at only in IDLE and on the last FRONT cycle
//   rd_addr     frame memory pixel address (registered)
//   rd_en       frame memory read strobe (registered)
//   rd_data     RGB565 pixel, valid one cycle after rd_en
//   vsync       frame sync, high for the whole SYNC period
//   href        line valid, high while dout carries pixel bytes
//   dout        pixel byte, 0 whenever href is low
//   frame_done  one-cycle pulse on the last cycle of each frame (undelayed)
//
// Pipeline: S0 counters/FSM -> S1 rd_addr/rd_en -> S2 rd_data -> S3 outputs.
// vsync/href ride through the same three stages so they line up with dout.
module ov7670_stream_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 288,
   parameter int V_SYNC   = 3,
   parameter int V_BACK   = 17,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        en,
   output logic [18:0] rd_addr,
   output logic        rd_en,
   input  logic [15:0] rd_data,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  dout,
   output logic        frame_done
);

   localparam int L    = 2*H_ACTIVE + H_BLANK;
   localparam int HW   = $clog2(L);
   localparam int VM1  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
   localparam int VM2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
   localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
   localparam int VW   = $clog2(VMAX + 1);

   localparam logic [HW-1:0] H_LAST    = HW'(L - 1);
   localparam logic [HW-1:0] H_ACT_END = HW'(2*H_ACTIVE);
   localparam logic [18:0]   ADDR_MAX  = 19'(V_ACTIVE*H_ACTIVE - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SYNC   = 3'd1;
   localparam logic [2:0] ST_BACK   = 3'd2;
   localparam logic [2:0] ST_ACTIVE = 3'd3;
   localparam logic [2:0] ST_FRONT  = 3'd4;

   // S0 state
   logic [2:0]    state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
   logic [18:0]   addr_cnt_q, addr_cnt_d;

   // S1 registers; ctl = {vsync, href, odd byte}
   logic [18:0]   rd_addr_q, rd_addr_d;
   logic          rd_en_q, rd_en_d;
   logic [2:0]    ctl_p1_q, ctl_p1_d;

   // S2 / S3 registers
   logic [2:0]    ctl_p2_q, ctl_p2_d;
   logic [7:0]    hold_q, hold_d;
   logic          vsync_q, vsync_d;
   logic          href_q, href_d;
   logic [7:0]    dout_q, dout_d;

   // S0 decode
   logic [VW-1:0] v_last;
   logic          line_end;
   logic          vs0, hr0, rd0, last_cyc;

   always_comb begin
      v_last = '0;
      case (state_q)
         ST_SYNC:   v_last = VW'(V_SYNC - 1);
         ST_BACK:   v_last = VW'(V_BACK - 1);
         ST_ACTIVE: v_last = VW'(V_ACTIVE - 1);
         ST_FRONT:  v_last = VW'(V_FRONT - 1);
         default:   v_last = '0;
      endcase
   end

   assign line_end = (hcnt_q == H_LAST);
   assign vs0      = (state_q == ST_SYNC);
   assign hr0      = (state_q == ST_ACTIVE) && (hcnt_q < H_ACT_END);
   assign rd0      = hr0 && !hcnt_q[0];
   assign last_cyc = (state_q == ST_FRONT) && (vcnt_q == v_last) && line_end;

   // Frame sequencer
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      if (state_q == ST_IDLE) begin
         hcnt_d = '0;
         vcnt_d = '0;
         if (en) state_d = ST_SYNC;
      end else if (!line_end) begin
         hcnt_d = hcnt_q + 1'b1;
      end else begin
         hcnt_d = '0;
         if (vcnt_q != v_last) begin
            vcnt_d = vcnt_q + 1'b1;
         end else begin
            vcnt_d = '0;
            case (state_q)
               ST_SYNC:   state_d = ST_BACK;
               ST_BACK:   state_d = ST_ACTIVE;
               ST_ACTIVE: state_d = ST_FRONT;
               default:   state_d = en ? ST_SYNC : ST_IDLE;
            endcase
         end
      end
   end

   // Read address generation; the pointer saturates at the last pixel so a
   // mis-sized frame can never walk off the end of the memory.
   always_comb begin
      addr_cnt_d = addr_cnt_q;
      rd_addr_d  = rd_addr_q;
      rd_en_d    = rd0;
      if (state_d == ST_SYNC && state_q != ST_SYNC) begin
         addr_cnt_d = '0;
         rd_addr_d  = '0;
      end else if (rd0) begin
         rd_addr_d  = addr_cnt_q;
         addr_cnt_d = (addr_cnt_q == ADDR_MAX) ? addr_cnt_q : addr_cnt_q + 19'd1;
      end
   end

   // Output pipeline. The even byte comes straight from rd_data; its low half
   // is parked in hold_q because rd_data is only valid for that one cycle.
   always_comb begin
      ctl_p1_d = {vs0, hr0, hcnt_q[0]};
      ctl_p2_d = ctl_p1_q;
      vsync_d  = ctl_p2_q[2];
      href_d   = ctl_p2_q[1];
      hold_d   = hold_q;
      dout_d   = 8'h00;
      if (ctl_p2_q[1]) begin
         if (ctl_p2_q[0]) begin
            dout_d = hold_q;
         end else begin
            dout_d = rd_data[15:8];
            hold_d = rd_data[7:0];
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         addr_cnt_q <= '0;
         rd_addr_q  <= '0;
         rd_en_q    <= 1'b0;
         ctl_p1_q   <= '0;
         ctl_p2_q   <= '0;
         hold_q     <= '0;
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         dout_q     <= '0;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         addr_cnt_q <= addr_cnt_d;
         rd_addr_q  <= rd_addr_d;
         rd_en_q    <= rd_en_d;
         ctl_p1_q   <= ctl_p1_d;
         ctl_p2_q   <= ctl_p2_d;
         hold_q     <= hold_d;
         vsync_q    <= vsync_d;
         href_q     <= href_d;
         dout_q     <= dout_d;
      end
   end

   assign rd_addr    = rd_addr_q;
   assign rd_en      = rd_en_q;
   assign vsync      = vsync_q;
   assign href       = href_q;
   assign dout       = dout_q;
   assign frame_done = last_cyc;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: a small-geometry instance checked every cycle
// against a frame-position reference model, plus a full-width instance used
// to measure line and frame lengths.
module tb_ov7670_stream_gen;

   localparam int HA = 4, HB = 3, VS = 1, VB = 1, VA = 2, VF = 1;
   localparam int L  = 2*HA + HB;
   localparam int F  = (VS + VB + VA + VF) * L;

   localparam int WHA = 640, WHB = 288, WVS = 1, WVB = 1, WVA = 2, WVF = 1;
   localparam int WL  = 2*WHA + WHB;
   localparam int WF  = (WVS + WVB + WVA + WVF) * WL;

   logic        pclk = 1'b0;
   logic        rst = 1'b1, en = 1'b1;
   logic [18:0] rd_addr;
   logic        rd_en;
   logic [15:0] rd_data = 16'h0;
   logic        vsync, href, frame_done;
   logic [7:0]  dout;

   logic        rst_w = 1'b1, en_w = 1'b0;
   logic [18:0] rd_addr_w;
   logic        rd_en_w;
   logic [15:0] rd_data_w = 16'h1234;
   logic        vsync_w, href_w, frame_done_w;
   logic [7:0]  dout_w;

   ov7670_stream_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB),
                       .V_ACTIVE(VA), .V_FRONT(VF)) dut (
      .pclk(pclk), .rst(rst), .en(en), .rd_addr(rd_addr), .rd_en(rd_en),
      .rd_data(rd_data), .vsync(vsync), .href(href), .dout(dout),
      .frame_done(frame_done));

   ov7670_stream_gen #(.H_ACTIVE(WHA), .H_BLANK(WHB), .V_SYNC(WVS), .V_BACK(WVB),
                       .V_ACTIVE(WVA), .V_FRONT(WVF)) dut_w (
      .pclk(pclk), .rst(rst_w), .en(en_w), .rd_addr(rd_addr_w), .rd_en(rd_en_w),
      .rd_data(rd_data_w), .vsync(vsync_w), .href(href_w), .dout(dout_w),
      .frame_done(frame_done_w));

   initial forever #5 pclk = ~pclk;

   // frame memory: one-cycle read latency
   logic [15:0] mem [0:7];
   always @(posedge pclk) if (rd_en) rd_data <= mem[rd_addr[2:0]];

   int total = 0, bad = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: frame position counter plus output delay lines.
   bit         run_m = 0;
   int         pos_m = 0;
   logic [3:1] vs_h = '0, hr_h = '0;
   logic [7:0] db_h [1:3] = '{8'h0, 8'h0, 8'h0};
   logic       rd_h1 = 0;
   int         ad_h1 = 0;
   logic       c_vs = 0, c_hr = 0, c_rd = 0, c_fd = 0;
   logic [7:0] c_db = 0;
   int         c_ad = 0;

   task automatic model_step();
      int line, h, n;
      logic [15:0] w;
      bit act;
      if (rst) begin
         run_m = 0; pos_m = 0; vs_h = '0; hr_h = '0;
         db_h[1] = 0; db_h[2] = 0; db_h[3] = 0; rd_h1 = 0; ad_h1 = 0;
      end else begin
         vs_h = {vs_h[2], vs_h[1], c_vs};
         hr_h = {hr_h[2], hr_h[1], c_hr};
         db_h[3] = db_h[2]; db_h[2] = db_h[1]; db_h[1] = c_db;
         rd_h1 = c_rd; ad_h1 = c_ad;
         if (!run_m) begin
            if (en) begin run_m = 1; pos_m = 0; end
         end else if (pos_m == F-1) begin
            if (en) pos_m = 0; else begin run_m = 0; pos_m = 0; end
         end else pos_m++;
      end
      line = pos_m / L;
      h    = pos_m % L;
      act  = run_m && line >= VS+VB && line < VS+VB+VA && h < 2*HA;
      n    = (line - VS - VB)*HA + h/2;
      c_vs = run_m && line < VS;
      c_hr = act;
      c_rd = act && (h % 2 == 0);
      c_ad = act ? n : 0;
      c_db = 8'h00;
      if (act) begin
         w = mem[n];
         c_db = (h % 2 == 0) ? w[15:8] : w[7:0];
      end
      c_fd = run_m && pos_m == F-1;
   endtask

   int cyc = 0, fd_cnt = 0, last_fd = 0;
   int addr_log[$];
   int gap_log[$];

   task automatic compare_all();
      chk("vsync", vsync, vs_h[3]);
      chk("href", href, hr_h[3]);
      chk("dout", dout, db_h[3]);
      chk("rd_en", rd_en, rd_h1);
      if (rd_h1) chk("rd_addr", rd_addr, ad_h1);
      chk("frame_done", frame_done, c_fd);
      if (frame_done) begin
         if (fd_cnt > 0) gap_log.push_back(cyc - last_fd);
         fd_cnt++;
         last_fd = cyc;
      end
      if (rd_en) addr_log.push_back(int'(rd_addr));
   endtask

   task automatic tick();
      @(posedge pclk);
      model_step();
      cyc++;
      @(negedge pclk);
      compare_all();
   endtask

   task automatic wait_href(input string tag);
      int k = 0;
      while (!href && k < 200) begin tick(); k++; end
      chk(tag, href, 1'b1);
   endtask

   initial begin
      int entry, r1, f1, r2, fdc;
      logic prev;

      // reset with en high: reset wins
      tick(); tick();
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_vsync", vsync, 0);
      chk("rst_href", href, 0);
      chk("rst_dout", dout, 0);
      chk("rst_fd", frame_done, 0);

      // single frame
      for (int i = 0; i < 8; i++) mem[i] = 16'hA000 + 16'(i);
      rst = 0; en = 0; tick();
      fd_cnt = 0; addr_log.delete();
      en = 1; tick(); en = 0;
      repeat (F + 10) tick();
      chk("sf_fd_cnt", fd_cnt, 1);
      chk("sf_reads", addr_log.size(), 8);
      for (int i = 0; i < addr_log.size(); i++) chk("sf_addr", addr_log[i], i);

      // back-to-back frames
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      fd_cnt = 0; gap_log.delete(); addr_log.delete();
      en = 1; repeat (3*F + 2) tick();
      en = 0; repeat (F + 5) tick();
      chk("b2b_fd_cnt", fd_cnt, 4);
      chk("b2b_gaps", gap_log.size(), 3);
      for (int i = 0; i < gap_log.size(); i++) chk("b2b_gap", gap_log[i], F);
      chk("b2b_reads", addr_log.size(), 32);
      if (addr_log.size() > 8) chk("b2b_restart", addr_log[8], 0);

      // en dropped mid-frame: frame still completes
      fd_cnt = 0; addr_log.delete();
      en = 1; wait_href("drop_href_to");
      en = 0; repeat (F + 20) tick();
      chk("drop_reads", addr_log.size(), 8);
      chk("drop_fd_cnt", fd_cnt, 1);
      chk("drop_idle_vs", vsync, 0);
      chk("drop_idle_hr", href, 0);

      // reset while href is high
      fd_cnt = 0;
      en = 1; wait_href("rst_href_to");
      rst = 1; tick();
      chk("mid_rst_href", href, 0);
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_fd", frame_done, 0);
      rst = 0; en = 0; tick();
      addr_log.delete();
      en = 1; tick(); en = 0;
      repeat (F + 5) tick();
      chk("mid_rst_fd_cnt", fd_cnt, 1);
      chk("mid_rst_reads", addr_log.size(), 8);
      if (addr_log.size() > 0) chk("mid_rst_addr0", addr_log[0], 0);

      // random en / occasional reset
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 600; i++) begin
         en  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 0; en = 0; repeat (F + 5) tick();

      // full-width line and frame length
      rst_w = 0; tick();
      en_w = 1; tick(); entry = cyc; en_w = 0;
      r1 = -1; f1 = -1; r2 = -1; fdc = -1; prev = 0;
      for (int k = 0; k < WF + 100 && fdc < 0; k++) begin
         tick();
         if (href_w && !prev) begin
            if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
         end
         if (!href_w && prev && f1 < 0) f1 = cyc;
         if (frame_done_w) fdc = cyc;
         prev = href_w;
      end
      chk("w_first_href", r1 - entry, 3 + (WVS + WVB)*WL);
      chk("w_href_hi", f1 - r1, 2*WHA);
      chk("w_href_lo", r2 - f1, WHB);
      chk("w_frame_len", fdc - entry + 1, WF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
